// File: rtl/imem_loader.sv
// Instruction memory with a combinational fetch port, loaded from a length-prefixed
// big-endian byte stream; the cpu is held in reset until the load completes.
module imem_loader #(
  parameter int IADDRWIDTH = 16,
  parameter int IWIDTH     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IADDRWIDTH-1:0] iaddr,
  output logic [IWIDTH-1:0]     idata,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic [15:0]           words_loaded
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    RUN     = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  // words_loaded doubles as the write index: both clear at LEN_LO and step together.
  logic [15:0] words_loaded_q, words_loaded_d;

  logic [IWIDTH-1:0]     mem_q [DEPTH];
  logic                  accept;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [IWIDTH-1:0]     mem_wdata;
  logic                  iaddr_in_range;
  logic                  word_in_range;

  assign in_ready       = (state_q != RUN) & ~reload;
  assign accept         = in_valid & in_ready & ~rst;
  assign cpu_rst        = (state_q != RUN);
  assign load_done      = (state_q == RUN);
  assign words_loaded   = words_loaded_q;
  assign iaddr_in_range = ((iaddr >> DEPTH_LOG2) == {IADDRWIDTH{1'b0}});
  assign word_in_range  = ((words_loaded_q >> DEPTH_LOG2) == 16'h0000);
  assign mem_waddr      = words_loaded_q[DEPTH_LOG2-1:0];
  assign mem_wdata      = {hi_q, in_data};

  // Fetch read: out-of-range addresses return zero rather than aliasing.
  always_comb begin
    idata = {IWIDTH{1'b0}};
    if (iaddr_in_range) begin
      idata = mem_q[iaddr[DEPTH_LOG2-1:0]];
    end else begin
      idata = {IWIDTH{1'b0}};
    end
  end

  // Loader next-state: reload outranks any byte transfer.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    hi_d           = hi_q;
    words_loaded_d = words_loaded_q;
    mem_we         = 1'b0;
    if (reload) begin
      state_d = LEN_HI;
    end else if (accept) begin
      case (state_q)
        LEN_HI: begin
          len_d   = {in_data, len_q[7:0]};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d          = {len_q[15:8], in_data};
          words_loaded_d = 16'h0000;
          if ({len_q[15:8], in_data} != 16'h0000) begin
            state_d = DATA_HI;
          end else begin
            state_d = RUN;
          end
        end
        DATA_HI: begin
          hi_d    = in_data;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          mem_we         = word_in_range;
          words_loaded_d = words_loaded_q + 16'd1;
          if (words_loaded_d == len_q) begin
            state_d = RUN;
          end else begin
            state_d = DATA_HI;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = LEN_HI;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Loader state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= LEN_HI;
      len_q          <= 16'h0000;
      hi_q           <= 8'h00;
      words_loaded_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      hi_q           <= hi_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  // Memory array; deliberately untouched by rst so a program survives a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a full-size instance and a DEPTH_LOG2=2 instance.
module tb_imem_loader;

  localparam int K_IDATA = 0;
  localparam int K_CPU_RST = 1;
  localparam int K_DONE = 2;
  localparam int K_WORDS = 3;
  localparam int K_READY = 4;

  typedef struct {
    string       name;
    int          sel;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] iaddr_v [2];
  logic [15:0] idata_v [2];
  logic        in_valid_v [2];
  logic [7:0]  in_data_v [2];
  logic        in_ready_v [2];
  logic        reload_v [2];
  logic        cpu_rst_v [2];
  logic        load_done_v [2];
  logic [15:0] words_v [2];

  exp_t        exp_q[$];
  int          done_q0[$];
  int          done_q1[$];
  logic        ld_prev0 = 1'b0;
  logic        ld_prev1 = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  imem_loader #(.IADDRWIDTH(16), .IWIDTH(16), .DEPTH_LOG2(10)) dut0 (
    .clk(clk), .rst(rst), .iaddr(iaddr_v[0]), .idata(idata_v[0]),
    .in_valid(in_valid_v[0]), .in_data(in_data_v[0]), .in_ready(in_ready_v[0]),
    .reload(reload_v[0]), .cpu_rst(cpu_rst_v[0]), .load_done(load_done_v[0]),
    .words_loaded(words_v[0])
  );

  imem_loader #(.IADDRWIDTH(16), .IWIDTH(16), .DEPTH_LOG2(2)) dut1 (
    .clk(clk), .rst(rst), .iaddr(iaddr_v[1]), .idata(idata_v[1]),
    .in_valid(in_valid_v[1]), .in_data(in_data_v[1]), .in_ready(in_ready_v[1]),
    .reload(reload_v[1]), .cpu_rst(cpu_rst_v[1]), .load_done(load_done_v[1]),
    .words_loaded(words_v[1])
  );

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Monitor: drains queued expectations and checks each load completion.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_IDATA:   act = idata_v[e.sel];
        K_CPU_RST: act = {15'h0000, cpu_rst_v[e.sel]};
        K_DONE:    act = {15'h0000, load_done_v[e.sel]};
        K_WORDS:   act = words_v[e.sel];
        K_READY:   act = {15'h0000, in_ready_v[e.sel]};
        default:   act = 16'hxxxx;
      endcase
      check(e.name, act, e.val);
    end
    if (load_done_v[0] && !ld_prev0) begin
      if (done_q0.size() == 0) begin
        n_checks++;
        $display("FAIL dut0_done: unexpected completion, words_loaded %h", words_v[0]);
      end else begin
        check("dut0_done_words", words_v[0], 16'(done_q0.pop_front()));
      end
    end
    if (load_done_v[1] && !ld_prev1) begin
      if (done_q1.size() == 0) begin
        n_checks++;
        $display("FAIL dut1_done: unexpected completion, words_loaded %h", words_v[1]);
      end else begin
        check("dut1_done_words", words_v[1], 16'(done_q1.pop_front()));
      end
    end
    ld_prev0 = load_done_v[0];
    ld_prev1 = load_done_v[1];
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(int sel, int kind, logic [15:0] val, string name);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic probe(int sel, logic [15:0] addr, logic [15:0] val, string name);
    iaddr_v[sel] = addr;
    expect_out(sel, K_IDATA, val, name);
    cycle();
  endtask

  task automatic send_byte(int sel, logic [7:0] b);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    in_valid_v[sel] = 1'b1;
    in_data_v[sel]  = b;
    while (!acc && budget < 100) begin
      @(negedge clk);
      acc = in_ready_v[sel];
      cycle();
      budget++;
    end
    in_valid_v[sel] = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_byte: byte %h not accepted, in_ready stuck at 0", b);
    end
  endtask

  // Offers the byte only on random cycles; garbage on in_data while invalid.
  task automatic send_byte_rand(int sel, logic [7:0] b);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 200) begin
      in_valid_v[sel] = 1'($urandom_range(0, 1));
      in_data_v[sel]  = in_valid_v[sel] ? b : 8'($urandom_range(0, 255));
      @(negedge clk);
      acc = in_valid_v[sel] & in_ready_v[sel];
      cycle();
      budget++;
    end
    in_valid_v[sel] = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_byte_rand: byte %h not accepted", b);
    end
  endtask

  // One-cycle reload with a byte offered alongside it; that byte must be refused.
  task automatic do_reload(int sel, logic [15:0] exp_words, string tag);
    reload_v[sel]   = 1'b1;
    in_valid_v[sel] = 1'b1;
    in_data_v[sel]  = 8'hFF;
    expect_out(sel, K_READY, 16'd0, {tag, "_ready_in_reload"});
    cycle();
    reload_v[sel]   = 1'b0;
    in_valid_v[sel] = 1'b0;
    expect_out(sel, K_CPU_RST, 16'd1, {tag, "_cpu_rst"});
    expect_out(sel, K_DONE, 16'd0, {tag, "_load_done"});
    expect_out(sel, K_READY, 16'd1, {tag, "_ready"});
    expect_out(sel, K_WORDS, exp_words, {tag, "_words_hold"});
    cycle();
  endtask

  task automatic expect_run(int sel, logic [15:0] words, string tag);
    expect_out(sel, K_CPU_RST, 16'd0, {tag, "_cpu_rst"});
    expect_out(sel, K_DONE, 16'd1, {tag, "_load_done"});
    expect_out(sel, K_WORDS, words, {tag, "_words"});
    expect_out(sel, K_READY, 16'd0, {tag, "_ready_run"});
    cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb [6];
    rb = '{8'h00, 8'h02, 8'h56, 8'h78, 8'h9A, 8'hBC};
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      iaddr_v[s] = 16'h0000;
      in_valid_v[s] = 1'b0;
      in_data_v[s] = 8'h00;
      reload_v[s] = 1'b0;
    end
    cycle();
    cycle();
    rst = 1'b0;
    expect_out(0, K_CPU_RST, 16'd1, "rst_cpu_rst");
    expect_out(0, K_READY, 16'd1, "rst_in_ready");
    expect_out(0, K_DONE, 16'd0, "rst_load_done");
    expect_out(0, K_WORDS, 16'd0, "rst_words");
    expect_out(1, K_CPU_RST, 16'd1, "rst_cpu_rst_small");
    cycle();

    // Basic two-word load; mem[1] must not show the new word before the write edge.
    done_q0.push_back(2);
    send_byte(0, 8'h00); send_byte(0, 8'h02); send_byte(0, 8'h12);
    send_byte(0, 8'h34); send_byte(0, 8'hAB);
    iaddr_v[0] = 16'h0001;
    expect_out(0, K_IDATA, 16'h0000, "t1_no_bypass");
    expect_out(0, K_CPU_RST, 16'd1, "t1_cpu_rst_before_last");
    send_byte(0, 8'hCD);
    expect_out(0, K_IDATA, 16'hABCD, "t1_mem1_next_cycle");
    expect_run(0, 16'd2, "t1");
    probe(0, 16'h0000, 16'h1234, "t1_mem0");
    probe(0, 16'h0400, 16'h0000, "t1_oob_400");
    probe(0, 16'hFFFF, 16'h0000, "t1_oob_ffff");

    // Zero-length load goes straight to RUN.
    do_reload(0, 16'd2, "t2_reload");
    done_q0.push_back(0);
    send_byte(0, 8'h00);
    expect_out(0, K_CPU_RST, 16'd1, "t2_cpu_rst_mid");
    send_byte(0, 8'h00);
    expect_run(0, 16'd0, "t2");
    probe(0, 16'h0000, 16'h1234, "t2_mem0_kept");
    probe(0, 16'h0001, 16'hABCD, "t2_mem1_kept");

    // Reload from RUN, one-word load.
    do_reload(0, 16'd0, "t4_reload");
    done_q0.push_back(1);
    send_byte(0, 8'h00); send_byte(0, 8'h01); send_byte(0, 8'h55); send_byte(0, 8'hAA);
    expect_run(0, 16'd1, "t4");
    probe(0, 16'h0000, 16'h55AA, "t4_mem0");
    probe(0, 16'h0001, 16'hABCD, "t4_mem1_kept");

    // Two-word load with randomly gapped in_valid.
    do_reload(0, 16'd1, "t3_reload");
    done_q0.push_back(2);
    for (int i = 0; i < 6; i++) send_byte_rand(0, rb[i]);
    expect_run(0, 16'd2, "t3");
    probe(0, 16'h0000, 16'h5678, "t3_mem0");
    probe(0, 16'h0001, 16'h9ABC, "t3_mem1");

    // rst in the middle of a load.
    do_reload(0, 16'd2, "t5_reload");
    send_byte(0, 8'h00); send_byte(0, 8'h02); send_byte(0, 8'h12);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    expect_out(0, K_CPU_RST, 16'd1, "t5_cpu_rst");
    expect_out(0, K_READY, 16'd1, "t5_in_ready");
    expect_out(0, K_DONE, 16'd0, "t5_load_done");
    expect_out(0, K_WORDS, 16'd0, "t5_words");
    cycle();
    probe(0, 16'h0000, 16'h5678, "t5_mem0_kept");
    done_q0.push_back(1);
    send_byte(0, 8'h00); send_byte(0, 8'h01); send_byte(0, 8'h77); send_byte(0, 8'h88);
    expect_run(0, 16'd1, "t5_after");
    probe(0, 16'h0000, 16'h7788, "t5_mem0_new");

    // Reload with a half word pending: written words stay, the partial is dropped.
    do_reload(0, 16'd1, "t7_reload");
    send_byte(0, 8'h00); send_byte(0, 8'h03); send_byte(0, 8'h11); send_byte(0, 8'h22);
    send_byte(0, 8'h33); send_byte(0, 8'h44); send_byte(0, 8'h55);
    do_reload(0, 16'd2, "t7_midload");
    done_q0.push_back(1);
    send_byte(0, 8'h00); send_byte(0, 8'h01); send_byte(0, 8'h66); send_byte(0, 8'h77);
    expect_run(0, 16'd1, "t7");
    probe(0, 16'h0000, 16'h6677, "t7_mem0");
    probe(0, 16'h0001, 16'h3344, "t7_mem1");
    probe(0, 16'h0002, 16'h0000, "t7_mem2_untouched");

    // Four-word memory, five-word stream: the fifth word is discarded.
    done_q1.push_back(5);
    send_byte(1, 8'h00); send_byte(1, 8'h05);
    for (int k = 1; k <= 5; k++) begin
      send_byte(1, 8'(k * 17));
      send_byte(1, 8'(k * 17));
    end
    expect_run(1, 16'd5, "t6");
    for (int k = 0; k < 4; k++) probe(1, 16'(k), 16'((k + 1) * 16'h1111), "t6_mem");
    probe(1, 16'h0004, 16'h0000, "t6_oob_4");
    probe(1, 16'h0005, 16'h0000, "t6_oob_5");

    cycle();
    cycle();
    check("done_queues_drained", 16'(done_q0.size() + done_q1.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
